ctl_stack: RTL and testbench

Parametrised predication and call-return control stack for the pipelined processor. Generalises the fixed 32-entry single-lane enable shift register and the 64-bit call stack into one block with configurable lane count, enable depth and call depth, adding masked pushes, an ELSE mask operation, occupancy tracking and sticky overflow/underflow error flags. Sits beside the stage-2 (execute) logic: it receives one decoded control op per cycle and presents the registered lane-enable mask used to gate writeback and stores.

---
 rtl/ctl_stack.sv | 169 ++++++++++++++++
 tb/tb_ctl_stack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_stack.sv
// Predication enable stack plus optional call-return stack; all outputs registered.
// Define CTL_STACK_CALL_EN to build the call stack (CALL/RET, ret_addr, ret_valid, call_depth).
module ctl_stack #(
    parameter int LANES      = 1,
    parameter int EN_DEPTH   = 32,
    parameter int CALL_DEPTH = 4,
    parameter int AW         = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2:0]                        op,
    input  logic [LANES-1:0]                  cond,
    input  logic [AW-1:0]                     ret_in,
    input  logic                              err_clr,
    output logic [LANES-1:0]                  en,
    output logic                              any_en,
    output logic [$clog2(EN_DEPTH+1)-1:0]     en_depth,
    output logic [AW-1:0]                     ret_addr,
    output logic                              ret_valid,
    output logic [$clog2(CALL_DEPTH+1)-1:0]   call_depth,
    output logic                              err_ovf,
    output logic                              err_unf
);

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_ALLEN  = 3'd1;
    localparam logic [2:0] OP_PUSHEN = 3'd2;
    localparam logic [2:0] OP_POPEN  = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;
    localparam logic [2:0] OP_ELSE   = 3'd6;

    localparam int EDW = $clog2(EN_DEPTH+1);
    localparam int CDW = $clog2(CALL_DEPTH+1);
    localparam logic [EDW-1:0]   EN_FULL  = EDW'(EN_DEPTH);
    localparam logic [EDW-1:0]   EN_ONE   = EDW'(1);
    localparam logic [LANES-1:0] ALL_ONES = '1;

    logic [LANES-1:0] top_q, top_d;
    logic [LANES-1:0] saved_q [EN_DEPTH-1];
    logic [LANES-1:0] saved_d [EN_DEPTH-1];
    logic [EDW-1:0]   edep_q, edep_d;
    logic             any_en_q, any_en_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_evt, unf_evt;

`ifdef CTL_STACK_CALL_EN
    localparam logic [CDW-1:0] CALL_FULL = CDW'(CALL_DEPTH);

    logic [AW-1:0]  cs_q [CALL_DEPTH];
    logic [AW-1:0]  cs_d [CALL_DEPTH];
    logic [CDW-1:0] cdep_q, cdep_d;
    logic [AW-1:0]  ret_addr_q, ret_addr_d;
    logic           ret_valid_q, ret_valid_d;
`endif

    always_comb begin
        top_d   = top_q;
        saved_d = saved_q;
        edep_d  = edep_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
`ifdef CTL_STACK_CALL_EN
        cs_d        = cs_q;
        cdep_d      = cdep_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
`endif
        case (op)
            OP_ALLEN: top_d = ALL_ONES;
            OP_PUSHEN: begin
                saved_d[0] = top_q;
                for (int unsigned i = 1; i < EN_DEPTH-1; i++) saved_d[i] = saved_q[i-1];
                top_d = top_q & cond;
                if (edep_q == EN_FULL) ovf_evt = 1'b1;
                else                   edep_d  = edep_q + EN_ONE;
            end
            OP_POPEN: begin
                // Entries below the occupancy are always all ones, so shifting at depth 1 is harmless.
                for (int unsigned i = 0; i < EN_DEPTH-2; i++) saved_d[i] = saved_q[i+1];
                saved_d[EN_DEPTH-2] = ALL_ONES;
                if (edep_q == EN_ONE) begin
                    top_d   = ALL_ONES;
                    unf_evt = 1'b1;
                end else begin
                    top_d  = saved_q[0];
                    edep_d = edep_q - EN_ONE;
                end
            end
            OP_ELSE: top_d = ~top_q & ((edep_q == EN_ONE) ? ALL_ONES : saved_q[0]);
`ifdef CTL_STACK_CALL_EN
            OP_CALL: begin
                cs_d[0] = ret_in;
                for (int unsigned i = 1; i < CALL_DEPTH; i++) cs_d[i] = cs_q[i-1];
                if (cdep_q == CALL_FULL) ovf_evt = 1'b1;
                else                     cdep_d  = cdep_q + CDW'(1);
            end
            OP_RET: begin
                if (cdep_q == '0) begin
                    ret_addr_d = '0;
                    unf_evt    = 1'b1;
                end else begin
                    ret_addr_d  = cs_q[0];
                    ret_valid_d = 1'b1;
                    for (int unsigned i = 0; i < CALL_DEPTH-1; i++) cs_d[i] = cs_q[i+1];
                    cs_d[CALL_DEPTH-1] = '0;
                    cdep_d = cdep_q - CDW'(1);
                end
            end
`endif
            default: ;
        endcase
        any_en_d = |top_d;
        ovf_d    = (err_clr ? 1'b0 : ovf_q) | ovf_evt;
        unf_d    = (err_clr ? 1'b0 : unf_q) | unf_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q    <= ALL_ONES;
            for (int unsigned i = 0; i < EN_DEPTH-1; i++) saved_q[i] <= ALL_ONES;
            edep_q   <= EN_ONE;
            any_en_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            top_q    <= top_d;
            saved_q  <= saved_d;
            edep_q   <= edep_d;
            any_en_q <= any_en_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign en       = top_q;
    assign any_en   = any_en_q;
    assign en_depth = edep_q;
    assign err_ovf  = ovf_q;
    assign err_unf  = unf_q;

`ifdef CTL_STACK_CALL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CALL_DEPTH; i++) cs_q[i] <= '0;
            cdep_q      <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            cdep_q      <= cdep_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    assign ret_addr   = ret_addr_q;
    assign ret_valid  = ret_valid_q;
    assign call_depth = cdep_q;
`else
    logic unused_ret_in;
    assign unused_ret_in = ^ret_in;
    assign ret_addr      = '0;
    assign ret_valid     = 1'b0;
    assign call_depth    = '0;
`endif

endmodule

// File: tb/tb_ctl_stack.sv
// Bench for ctl_stack: directed vector table, call-stack sequences, and randomized ops
// checked against a queue-based reference model.
module tb_ctl_stack;

    localparam int LANES      = 4;
    localparam int EN_DEPTH   = 4;
    localparam int CALL_DEPTH = 2;
    localparam int AW         = 16;

    localparam logic [2:0] NONE = 3'd0, ALLEN = 3'd1, PUSH = 3'd2, POP = 3'd3,
                           CALL = 3'd4, RET = 3'd5, ELSE = 3'd6;

    logic             clk;
    logic             reset;
    logic [2:0]       op;
    logic [LANES-1:0] cond;
    logic [AW-1:0]    ret_in;
    logic             err_clr;
    logic [LANES-1:0] en;
    logic             any_en;
    logic [2:0]       en_depth;
    logic [AW-1:0]    ret_addr;
    logic             ret_valid;
    logic [1:0]       call_depth;
    logic             err_ovf;
    logic             err_unf;

    ctl_stack #(
        .LANES(LANES),
        .EN_DEPTH(EN_DEPTH),
        .CALL_DEPTH(CALL_DEPTH),
        .AW(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .cond(cond),
        .ret_in(ret_in),
        .err_clr(err_clr),
        .en(en),
        .any_en(any_en),
        .en_depth(en_depth),
        .ret_addr(ret_addr),
        .ret_valid(ret_valid),
        .call_depth(call_depth),
        .err_ovf(err_ovf),
        .err_unf(err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, exp);
        end
    endtask

    // Inputs change only after a falling edge; outputs are checked at the following falling edge.
    task automatic drive(input logic [2:0] o, input logic [3:0] c, input logic [15:0] r,
                         input logic clr, input logic rst);
        op = o; cond = c; ret_in = r; err_clr = clr; reset = rst;
        @(posedge clk);
        @(negedge clk);
        step++;
    endtask

    // Reference model: queues hold the stacks, element 0 is the top.
    logic [3:0]  m_en[$];
    logic [15:0] m_cs[$];
    logic [15:0] m_ra;
    logic        m_rv, m_ovf, m_unf;

    task automatic m_reset();
        m_en = {4'hF};
        m_cs = {};
        m_ra = '0;
        m_rv = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic m_step(input logic [2:0] o, input logic [3:0] c, input logic [15:0] r,
                          input logic clr, input logic rst);
        logic oe, ue;
        logic [3:0] below;
        if (rst) begin
            m_reset();
            return;
        end
        oe = 1'b0; ue = 1'b0; m_rv = 1'b0;
        case (o)
            ALLEN: m_en[0] = 4'hF;
            PUSH: begin
                m_en.push_front(m_en[0] & c);
                if (m_en.size() > EN_DEPTH) begin void'(m_en.pop_back()); oe = 1'b1; end
            end
            POP: begin
                if (m_en.size() == 1) begin m_en[0] = 4'hF; ue = 1'b1; end
                else void'(m_en.pop_front());
            end
            ELSE: begin
                below = (m_en.size() > 1) ? m_en[1] : 4'hF;
                m_en[0] = ~m_en[0] & below;
            end
`ifdef CTL_STACK_CALL_EN
            CALL: begin
                m_cs.push_front(r);
                if (m_cs.size() > CALL_DEPTH) begin void'(m_cs.pop_back()); oe = 1'b1; end
            end
            RET: begin
                if (m_cs.size() == 0) begin m_ra = '0; ue = 1'b1; end
                else begin m_ra = m_cs.pop_front(); m_rv = 1'b1; end
            end
`endif
            default: ;
        endcase
        m_ovf = (clr ? 1'b0 : m_ovf) | oe;
        m_unf = (clr ? 1'b0 : m_unf) | ue;
    endtask

    task automatic check_model();
        chk("en",         32'(en),         32'(m_en[0]));
        chk("any_en",     32'(any_en),     32'(m_en[0] != 4'h0));
        chk("en_depth",   32'(en_depth),   32'(m_en.size()));
        chk("ret_addr",   32'(ret_addr),   32'(m_ra));
        chk("ret_valid",  32'(ret_valid),  32'(m_rv));
        chk("call_depth", 32'(call_depth), 32'(m_cs.size()));
        chk("err_ovf",    32'(err_ovf),    32'(m_ovf));
        chk("err_unf",    32'(err_unf),    32'(m_unf));
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] cond;
        logic       clr;
        logic       rst;
        logic [3:0] en;
        int         dep;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] o, logic [3:0] c, logic clr, logic rst,
                                logic [3:0] e, int d, logic ov, logic un);
        vec_t v;
        v.op = o; v.cond = c; v.clr = clr; v.rst = rst;
        v.en = e; v.dep = d; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    initial begin
        op = NONE; cond = '0; ret_in = '0; err_clr = 1'b0; reset = 1'b1;
        @(negedge clk);

        //                op     cond  clr   rst   en    dep ovf   unf
        tbl.push_back(mk(NONE, 4'h0, 1'b0, 1'b1, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(NONE, 4'h0, 1'b0, 1'b0, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'h5, 1'b0, 1'b0, 4'h5, 2, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'h3, 1'b0, 1'b0, 4'h1, 3, 1'b0, 1'b0));
        tbl.push_back(mk(ELSE, 4'h0, 1'b0, 1'b0, 4'h4, 3, 1'b0, 1'b0));
        tbl.push_back(mk(POP,  4'h0, 1'b0, 1'b0, 4'h5, 2, 1'b0, 1'b0));
        tbl.push_back(mk(POP,  4'h0, 1'b0, 1'b0, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b0, 1'b0, 4'hF, 2, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b0, 1'b0, 4'hF, 3, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b0, 1'b0, 4'hF, 4, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b0, 1'b0, 4'hF, 4, 1'b1, 1'b0));
        tbl.push_back(mk(POP,  4'h0, 1'b0, 1'b0, 4'hF, 3, 1'b1, 1'b0));
        tbl.push_back(mk(POP,  4'h0, 1'b0, 1'b0, 4'hF, 2, 1'b1, 1'b0));
        tbl.push_back(mk(POP,  4'h0, 1'b0, 1'b0, 4'hF, 1, 1'b1, 1'b0));
        tbl.push_back(mk(POP,  4'h0, 1'b0, 1'b0, 4'hF, 1, 1'b1, 1'b1));
        tbl.push_back(mk(NONE, 4'h0, 1'b1, 1'b0, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hA, 1'b0, 1'b0, 4'hA, 2, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hC, 1'b0, 1'b0, 4'h8, 3, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'h1, 1'b0, 1'b1, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(NONE, 4'h0, 1'b0, 1'b0, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(ELSE, 4'h0, 1'b0, 1'b0, 4'h0, 1, 1'b0, 1'b0));
        tbl.push_back(mk(ALLEN,4'h0, 1'b0, 1'b0, 4'hF, 1, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'h6, 1'b0, 1'b0, 4'h6, 2, 1'b0, 1'b0));
        tbl.push_back(mk(ALLEN,4'h0, 1'b0, 1'b0, 4'hF, 2, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b0, 1'b0, 4'hF, 3, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b0, 1'b0, 4'hF, 4, 1'b0, 1'b0));
        tbl.push_back(mk(PUSH, 4'hF, 1'b1, 1'b0, 4'hF, 4, 1'b1, 1'b0));
        tbl.push_back(mk(NONE, 4'h0, 1'b1, 1'b0, 4'hF, 4, 1'b0, 1'b0));
        tbl.push_back(mk(7,    4'h0, 1'b0, 1'b0, 4'hF, 4, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].cond, 16'h0, tbl[i].clr, tbl[i].rst);
            chk("tbl_en",        32'(en),         32'(tbl[i].en));
            chk("tbl_any_en",    32'(any_en),     32'(tbl[i].en != 4'h0));
            chk("tbl_en_depth",  32'(en_depth),   32'(tbl[i].dep));
            chk("tbl_err_ovf",   32'(err_ovf),    32'(tbl[i].ovf));
            chk("tbl_err_unf",   32'(err_unf),    32'(tbl[i].unf));
            chk("tbl_ret_valid", 32'(ret_valid),  32'h0);
            chk("tbl_call_depth",32'(call_depth), 32'h0);
        end

`ifdef CTL_STACK_CALL_EN
        drive(NONE, 4'h0, 16'h0, 1'b0, 1'b1);
        drive(CALL, 4'h0, 16'h0010, 1'b0, 1'b0);
        chk("call1_depth", 32'(call_depth), 32'd1);
        drive(CALL, 4'h0, 16'h0020, 1'b0, 1'b0);
        chk("call2_depth", 32'(call_depth), 32'd2);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("ret1_addr",  32'(ret_addr),  32'h0020);
        chk("ret1_valid", 32'(ret_valid), 32'd1);
        chk("ret1_depth", 32'(call_depth), 32'd1);
        drive(NONE, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("ret1_pulse", 32'(ret_valid), 32'd0);
        chk("ret1_hold",  32'(ret_addr),  32'h0020);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("ret2_addr",  32'(ret_addr),  32'h0010);
        chk("ret2_valid", 32'(ret_valid), 32'd1);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("ret3_valid", 32'(ret_valid), 32'd0);
        chk("ret3_addr",  32'(ret_addr),  32'h0);
        chk("ret3_unf",   32'(err_unf),   32'd1);
        chk("ret3_ovf",   32'(err_ovf),   32'd0);
        drive(CALL, 4'h0, 16'hAAAA, 1'b1, 1'b0);
        drive(CALL, 4'h0, 16'hBBBB, 1'b0, 1'b0);
        chk("callB_ovf", 32'(err_ovf), 32'd0);
        drive(CALL, 4'h0, 16'hCCCC, 1'b0, 1'b0);
        chk("callC_ovf",   32'(err_ovf),    32'd1);
        chk("callC_depth", 32'(call_depth), 32'd2);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("retC_addr", 32'(ret_addr), 32'hCCCC);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("retB_addr",  32'(ret_addr),  32'hBBBB);
        chk("retB_valid", 32'(ret_valid), 32'd1);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("retU_valid", 32'(ret_valid), 32'd0);
        chk("retU_unf",   32'(err_unf),   32'd1);
`else
        drive(NONE, 4'h0, 16'h0, 1'b0, 1'b1);
        drive(CALL, 4'h0, 16'h1234, 1'b0, 1'b0);
        chk("nocall_depth", 32'(call_depth), 32'd0);
        drive(RET, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("noret_valid", 32'(ret_valid), 32'd0);
        chk("noret_addr",  32'(ret_addr),  32'h0);
        chk("noret_unf",   32'(err_unf),   32'd0);
        drive(CALL, 4'h0, 16'h5678, 1'b0, 1'b0);
        chk("nocall_ovf", 32'(err_ovf), 32'd0);
`endif

        m_reset();
        drive(NONE, 4'h0, 16'h0, 1'b0, 1'b1);
        check_model();
        for (int n = 0; n < 4000; n++) begin
            logic [2:0]  o;
            logic [3:0]  c;
            logic [15:0] r;
            logic        clr, rst;
            o   = 3'($urandom_range(0, 7));
            c   = 4'($urandom);
            r   = 16'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            m_step(o, c, r, clr, rst);
            drive(o, c, r, clr, rst);
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
